glitch_sequencer: RTL

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arms on a single-cycle request, then for each attempt waits a
// programmable number of sync_in rising edges, drives a fixed-width glitch pulse,
// idles for a fixed gap, and grows the edge delay for the next attempt.
module glitch_sequencer #(
  parameter int unsigned DELAY_START = 4,
  parameter int unsigned DELAY_STEP  = 1,
  parameter int unsigned ATTEMPTS    = 8,
  parameter int unsigned PULSE_WIDTH = 2,
  parameter int unsigned GAP         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       abort,
  input  logic       sync_in,
  output logic       glitch,
  output logic       busy,
  output logic [7:0] attempt,
  output logic       done
);

  localparam logic [15:0] DLY_START = 16'(DELAY_START);
  localparam logic [15:0] DLY_STEP  = 16'(DELAY_STEP);
  localparam logic [7:0]  LAST_ATT  = 8'(ATTEMPTS - 1);
  localparam logic [15:0] PW_LAST   = 16'(PULSE_WIDTH - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t      state;
  logic        sync_d;
  logic        sync_vld;
  logic        sync_rise;
  logic        wait_hit;
  logic [15:0] edge_cnt;
  logic [15:0] delay_cur;
  logic [15:0] tmr;

  // Delay growth clamps at full scale instead of wrapping back to a short delay.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Register sync_in once; sync_vld masks the first cycle after reset so a level
  // that is already high is not mistaken for a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d   <= 1'b0;
      sync_vld <= 1'b0;
    end else begin
      sync_d   <= sync_in;
      sync_vld <= 1'b1;
    end
  end

  assign sync_rise = sync_in & ~sync_d & sync_vld;

  // Leave WAIT when the target count is already met (covers a zero delay) or is
  // reached by the edge arriving this cycle.
  assign wait_hit = (edge_cnt == delay_cur) ||
                    (sync_rise && ((edge_cnt + 16'd1) == delay_cur));

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      glitch    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      attempt   <= 8'd0;
      delay_cur <= DLY_START;
      edge_cnt  <= 16'd0;
      tmr       <= 16'd0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state  <= ST_IDLE;
        glitch <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (arm && !abort) begin
              state     <= ST_WAIT;
              busy      <= 1'b1;
              delay_cur <= DLY_START;
              attempt   <= 8'd0;
              edge_cnt  <= 16'd0;
            end
          end
          ST_WAIT: begin
            if (sync_rise) edge_cnt <= edge_cnt + 16'd1;
            if (wait_hit) begin
              state  <= ST_PULSE;
              glitch <= 1'b1;
              tmr    <= 16'd0;
            end
          end
          ST_PULSE: begin
            if (tmr == PW_LAST) begin
              state  <= ST_GAP;
              glitch <= 1'b0;
              tmr    <= 16'd0;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
          ST_GAP: begin
            if (tmr == GAP_LAST) begin
              if (attempt == LAST_ATT) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= ST_WAIT;
                attempt   <= attempt + 8'd1;
                delay_cur <= sat_add16(delay_cur, DLY_STEP);
                edge_cnt  <= 16'd0;
              end
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
